// File: rtl/score_keeper.sv
// score_keeper: multi-digit BCD point counter with edge-detected hits, win latch,
// one-cycle playfield restart pulse and active-low 7-segment digit drive.
module score_keeper #(
    parameter int NUM_DIGITS = 2,
    parameter int WIN_SCORE  = 7
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    dir,
    input  logic                    led,
    input  logic                    clear,
    output logic                    freset,
    output logic                    win,
    output logic [4*NUM_DIGITS-1:0] score_bcd,
    output logic [7*NUM_DIGITS-1:0] score_seg
);
    typedef enum logic {PLAY, WON} state_t;

    function automatic logic [4*NUM_DIGITS-1:0] to_bcd(input int v);
        logic [4*NUM_DIGITS-1:0] r;
        int                      x;
        x = v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r[4*i+:4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    if (NUM_DIGITS < 1 || NUM_DIGITS > 4 || WIN_SCORE < 1 || WIN_SCORE > 10**NUM_DIGITS - 1) begin : g_bad_param
        $error("score_keeper: illegal NUM_DIGITS/WIN_SCORE");
    end

    localparam logic [4*NUM_DIGITS-1:0] WIN_BCD = to_bcd(WIN_SCORE);

    state_t                  state_q;
    logic [4*NUM_DIGITS-1:0] score_q, score_d;
    logic                    win_q, freset_q, hit_q;
    logic                    hit, point, carry, nz;

    assign hit   = led & dir;
    assign point = hit & ~hit_q;

    // Ripple-carry BCD increment; WIN_SCORE caps the count before any wrap.
    always_comb begin
        score_d = score_q;
        carry   = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            score_d[4*i+:4] = (carry && score_q[4*i+:4] == 4'd9) ? 4'd0 : score_q[4*i+:4] + {3'd0, carry};
            carry = carry && score_q[4*i+:4] == 4'd9;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= PLAY;
            score_q  <= '0;
            win_q    <= 1'b0;
            freset_q <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            hit_q    <= hit;
            freset_q <= 1'b0;
            if (clear) begin
                state_q <= PLAY;
                score_q <= '0;
                win_q   <= 1'b0;
            end else if (state_q == PLAY && point) begin
                score_q  <= score_d;
                freset_q <= 1'b1;
                if (score_d == WIN_BCD) begin
                    state_q <= WON;
                    win_q   <= 1'b1;
                end
            end
        end
    end

    // Blank a digit while it and every digit above it are zero.
    always_comb begin
        score_seg = '1;
        nz        = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nz = nz | (score_q[4*i+:4] != 4'd0);
            score_seg[7*i+:7] = nz ? seg7(score_q[4*i+:4]) : 7'b1111111;
        end
    end

    assign score_bcd = score_q;
    assign win       = win_q;
    assign freset    = freset_q;
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: three score_keeper instances sharing stimulus, each checked every
// cycle against an integer-score reference model.
module tb_score_keeper;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic dir = 1'b0, led = 1'b0, clear = 1'b0;

    logic        fr_a, win_a, fr_b, win_b, fr_c, win_c;
    logic [7:0]  bcd_a, bcd_b;
    logic [11:0] bcd_c;
    logic [13:0] seg_a, seg_b;
    logic [20:0] seg_c;

    score_keeper #(.NUM_DIGITS(2), .WIN_SCORE(7)) u_a (
        .clock(clock), .reset(reset), .dir(dir), .led(led), .clear(clear),
        .freset(fr_a), .win(win_a), .score_bcd(bcd_a), .score_seg(seg_a));
    score_keeper #(.NUM_DIGITS(2), .WIN_SCORE(15)) u_b (
        .clock(clock), .reset(reset), .dir(dir), .led(led), .clear(clear),
        .freset(fr_b), .win(win_b), .score_bcd(bcd_b), .score_seg(seg_b));
    score_keeper #(.NUM_DIGITS(3), .WIN_SCORE(105)) u_c (
        .clock(clock), .reset(reset), .dir(dir), .led(led), .clear(clear),
        .freset(fr_c), .win(win_c), .score_bcd(bcd_c), .score_seg(seg_c));

    always #5 clock = ~clock;

    logic [31:0] obs_bcd [3];
    logic [31:0] obs_seg [3];
    logic        obs_win [3];
    logic        obs_fr  [3];
    assign obs_bcd[0] = {24'd0, bcd_a};
    assign obs_bcd[1] = {24'd0, bcd_b};
    assign obs_bcd[2] = {20'd0, bcd_c};
    assign obs_seg[0] = {18'h3ffff, seg_a};
    assign obs_seg[1] = {18'h3ffff, seg_b};
    assign obs_seg[2] = {11'h7ff, seg_c};
    assign obs_win[0] = win_a;
    assign obs_win[1] = win_b;
    assign obs_win[2] = win_c;
    assign obs_fr[0]  = fr_a;
    assign obs_fr[1]  = fr_b;
    assign obs_fr[2]  = fr_c;

    int       total = 0;
    int       bad = 0;
    int       wscore [3] = '{7, 15, 105};
    int       ndig [3]   = '{2, 2, 3};
    int       score [3];
    bit       won [3];
    bit       fr [3];
    bit       prev_hit;
    logic [6:0] tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_bcd(input int s);
        logic [31:0] r;
        int          x;
        x = s;
        for (int i = 0; i < 8; i++) begin
            r[4*i+:4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_seg(input int s, input int nd);
        logic [31:0] r;
        int          p;
        r = '1;
        p = 1;
        for (int i = 0; i < nd; i++) begin
            r[7*i+:7] = (s / p == 0) ? 7'b1111111 : tbl[(s / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    task automatic model_step();
        bit h, pt;
        h  = led & dir;
        pt = h & ~prev_hit;
        for (int k = 0; k < 3; k++) begin
            if (!reset) begin
                score[k] = 0; won[k] = 0; fr[k] = 0;
            end else if (clear) begin
                score[k] = 0; won[k] = 0; fr[k] = 0;
            end else if (!won[k] && pt) begin
                score[k]++;
                fr[k] = 1;
                if (score[k] == wscore[k]) won[k] = 1;
            end else begin
                fr[k] = 0;
            end
        end
        prev_hit = reset ? h : 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bcd%0d", k), obs_bcd[k], exp_bcd(score[k]));
            chk($sformatf("seg%0d", k), obs_seg[k], exp_seg(score[k], ndig[k]));
            chk($sformatf("win%0d", k), {31'd0, obs_win[k]}, {31'd0, won[k]});
            chk($sformatf("freset%0d", k), {31'd0, obs_fr[k]}, {31'd0, fr[k]});
        end
    endtask

    task automatic pulse();
        led = 1'b1; dir = 1'b1;
        tick();
        led = 1'b0;
        tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    int cnt;

    initial begin
        // reset held two cycles
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("rst_seg_a", obs_seg[0], 32'hffffffff);
        chk("rst_bcd_b", obs_bcd[1], 32'd0);

        // held hit scores once, one freset pulse
        led = 1'b1; dir = 1'b1;
        cnt = 0;
        repeat (40) begin
            tick();
            cnt += int'(fr_a);
        end
        chk("held_fr_width", 32'(cnt), 32'd1);
        chk("held_score", obs_bcd[0], 32'h1);
        led = 1'b0; dir = 1'b0;
        tick();

        // dir gates led
        led = 1'b1;
        tick(); tick();
        led = 1'b0;
        tick();

        // B: 8 then 5 more through the 9->10 carry; A wins at 7
        do_clear();
        for (int n = 1; n <= 13; n++) begin
            led = 1'b1; dir = 1'b1;
            tick();
            if (n == 7) begin
                chk("win_with_pulse_w", {31'd0, win_a}, 32'd1);
                chk("win_with_pulse_f", {31'd0, fr_a}, 32'd1);
            end
            if (n == 10) chk("carry_b", obs_bcd[1], 32'h10);
            led = 1'b0;
            tick();
        end
        chk("b13_bcd", obs_bcd[1], 32'h13);
        chk("b13_seg", {18'd0, seg_b}, {18'd0, 7'b1111001, 7'b0110000});
        chk("a_hold7", obs_bcd[0], 32'h7);

        // clear in WON with hit held, then re-hit
        led = 1'b1; dir = 1'b1;
        tick();
        do_clear();
        tick(); tick();
        chk("clr_held_a", obs_bcd[0], 32'd0);
        chk("clr_held_w", {31'd0, win_a}, 32'd0);
        led = 1'b0;
        tick();
        pulse();
        chk("rehit_a", obs_bcd[0], 32'h1);

        // reset right after a point
        led = 1'b1; dir = 1'b1;
        tick();
        reset = 1'b0; led = 1'b0;
        tick();
        chk("rst_after_pt_f", {31'd0, fr_a}, 32'd0);
        chk("rst_after_pt_s", obs_bcd[0], 32'd0);
        reset = 1'b1;
        tick();
        pulse(); pulse();
        led = 1'b1; dir = 1'b1; clear = 1'b1;
        tick();
        clear = 1'b0; led = 1'b0;
        chk("pt_and_clear", obs_bcd[0], 32'd0);
        tick();

        // run C through several carries to its win
        do_clear();
        repeat (110) pulse();
        chk("c_win", {31'd0, win_c}, 32'd1);
        chk("c_score", obs_bcd[2], 32'h105);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            led   = 1'($urandom_range(0, 1));
            dir   = ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 39) == 0);
            reset = ($urandom_range(0, 149) != 0);
            tick();
        end
        reset = 1'b1; clear = 1'b0; led = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
